// File: rtl/mult_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mult_pkg
//  Description : Shared types and sizing helpers for the iterative radix-4
//                multiplier (FSM state encoding, iteration count, counter
//                width).
//  Revision    : 1.0 - initial release
// ============================================================================
package mult_pkg;

  // Controller states; values are fixed so the encoding is stable across tools.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  // Number of radix-4 iterations needed for a data_w-bit multiplier.
  function automatic int iter_count(input int data_w);
    return data_w / 2;
  endfunction

  // Width of the iteration down-counter (never narrower than one bit).
  function automatic int cnt_width(input int data_w);
    return (data_w / 2 > 1) ? $clog2(data_w / 2) : 1;
  endfunction

endpackage : mult_pkg
`default_nettype wire

// File: rtl/mult_radix4_pp.sv
`default_nettype none
// ============================================================================
//  Module      : mult_radix4_pp
//  Description : Radix-4 partial-product selector. Returns digit * a for a
//                2-bit unsigned digit, i.e. one of {0, A, 2A, 3A}.
//  Revision    : 1.0 - initial release
//  Ports       : a     in  DATA_W    unsigned multiplicand
//                digit in  2         multiplier digit (two LSBs)
//                pp    out DATA_W+2  selected partial product
// ============================================================================
module mult_radix4_pp #(
  parameter int DATA_W = 16
) (
  input  logic [DATA_W-1:0] a,
  input  logic [1:0]        digit,
  output logic [DATA_W+1:0] pp
);

  logic [DATA_W+1:0] w_a1;
  logic [DATA_W+1:0] w_a2;

  assign w_a1 = {2'b00, a};
  assign w_a2 = {1'b0, a, 1'b0};

  always_comb begin
    pp = '0;
    case (digit)
      2'd0:    pp = '0;
      2'd1:    pp = w_a1;
      2'd2:    pp = w_a2;
      2'd3:    pp = w_a1 + w_a2;
      default: pp = '0;
    endcase
  end

endmodule : mult_radix4_pp
`default_nettype wire

// File: rtl/mult_iter.sv
`default_nettype none
// ============================================================================
//  Module      : mult_iter
//  Description : Iterative radix-4 multiplier for the execute stage. Takes
//                two DATA_W-bit forwarded operands, retires two multiplier
//                bits per cycle and returns a 2*DATA_W-bit product. busy
//                stalls the pipeline front while the multiply runs.
//  Revision    : 1.0 - initial release
//  Ports       : clk       in  1         rising-edge clock
//                arst_n    in  1         asynchronous active-low reset
//                start     in  1         request (sampled in IDLE/DONE)
//                signed_op in  1         1 = two's-complement operands
//                op_a      in  DATA_W    multiplicand
//                op_b      in  DATA_W    multiplier
//                busy      out 1         high while calculating
//                done      out 1         one-cycle result-valid pulse
//                product   out 2*DATA_W  result, held until next result
//  Config      : MULT_EARLY_EXIT_EN - finish as soon as the remaining
//                multiplier bits are all zero (minimum one CALC cycle).
// ============================================================================
module mult_iter
  import mult_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic                clk,
  input  logic                arst_n,
  input  logic                start,
  input  logic                signed_op,
  input  logic [DATA_W-1:0]   op_a,
  input  logic [DATA_W-1:0]   op_b,
  output logic                busy,
  output logic                done,
  output logic [2*DATA_W-1:0] product
);

  localparam int             ITER     = iter_count(DATA_W);
  localparam int             CNT_W    = cnt_width(DATA_W);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ITER - 1);

  state_e                r_state;
  logic [DATA_W-1:0]     r_a;
  logic [DATA_W-1:0]     r_b;
  // The accumulator's two LSBs are always zero between iterations, so only
  // the upper 2*DATA_W-2 bits are stored.
  logic [2*DATA_W-3:0]   r_acc;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_neg;
  logic [2*DATA_W-1:0]   r_product;

  logic [DATA_W-1:0]     w_abs_a;
  logic [DATA_W-1:0]     w_abs_b;
  logic                  w_neg;
  logic [DATA_W+1:0]     w_pp;
  logic [DATA_W+1:0]     w_upper;
  logic [2*DATA_W-1:0]   w_acc_nxt;
  logic [DATA_W-1:0]     w_b_nxt;
  logic [2*DATA_W-1:0]   w_mag;
  logic [2*DATA_W-1:0]   w_result;
  logic                  w_last;

  // Operand magnitudes; -0x8000 wraps to 0x8000, which is the exact
  // unsigned magnitude.
  assign w_abs_a = (signed_op && op_a[DATA_W-1]) ? -op_a : op_a;
  assign w_abs_b = (signed_op && op_b[DATA_W-1]) ? -op_b : op_b;
  assign w_neg   = signed_op & (op_a[DATA_W-1] ^ op_b[DATA_W-1]);

  mult_radix4_pp #(
    .DATA_W (DATA_W)
  ) u_pp (
    .a     (r_a),
    .digit (r_b[1:0]),
    .pp    (w_pp)
  );

  // Add the partial product into the upper half, then shift right by two.
  // The sum fits in DATA_W+2 bits because the running product is bounded
  // by A * 4^(k+1).
  assign w_upper   = {2'b00, r_acc[2*DATA_W-3:DATA_W-2]} + w_pp;
  assign w_acc_nxt = {w_upper, r_acc[DATA_W-3:0]};
  assign w_b_nxt   = r_b >> 2;

`ifdef MULT_EARLY_EXIT_EN
  // Leaving early skips 'r_cnt' further shifts; realign the magnitude here.
  assign w_last = (r_cnt == '0) || (w_b_nxt == '0);
  assign w_mag  = w_acc_nxt >> {r_cnt, 1'b0};
`else
  assign w_last = (r_cnt == '0);
  assign w_mag  = w_acc_nxt;
`endif

  assign w_result = r_neg ? -w_mag : w_mag;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_state   <= IDLE;
      r_a       <= '0;
      r_b       <= '0;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_neg     <= 1'b0;
      r_product <= '0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (start) begin
            r_a     <= w_abs_a;
            r_b     <= w_abs_b;
            r_neg   <= w_neg;
            r_acc   <= '0;
            r_cnt   <= CNT_LOAD;
            r_state <= CALC;
          end else begin
            r_state <= IDLE;
          end
        end
        CALC: begin
          r_acc <= w_acc_nxt[2*DATA_W-1:2];
          r_b   <= w_b_nxt;
          r_cnt <= r_cnt - CNT_W'(1);
          if (w_last) begin
            r_product <= w_result;
            r_state   <= DONE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy    = (r_state == CALC);
  assign done    = (r_state == DONE);
  assign product = r_product;

endmodule : mult_iter
`default_nettype wire

// File: tb/tb_mult_iter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mult_iter
//  Description : Directed self-checking bench for mult_iter (DATA_W = 16).
//                Cycle 0 is the cycle in which start is high; outputs are
//                sampled on the falling edge.
//  Revision    : 1.0 - initial release
//  Config      : MULT_EARLY_EXIT_EN - expected latencies follow the macro.
// ============================================================================
module tb_mult_iter;

`ifdef MULT_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        arst_n;
  logic        start;
  logic        signed_op;
  logic [15:0] op_a;
  logic [15:0] op_b;
  logic        busy;
  logic        done;
  logic [31:0] product;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        s;
    logic [31:0] p;
    int          lat;
  } vec_t;

  always #5 clk = ~clk;

  mult_iter #(
    .DATA_W (16)
  ) dut (
    .clk       (clk),
    .arst_n    (arst_n),
    .start     (start),
    .signed_op (signed_op),
    .op_a      (op_a),
    .op_b      (op_b),
    .busy      (busy),
    .done      (done),
    .product   (product)
  );

  // Raise start with the given operands during the next cycle (cycle 0).
  task automatic start_op(input logic [15:0] a, input logic [15:0] b, input logic s);
    @(negedge clk);
    start     = 1'b1;
    op_a      = a;
    op_b      = b;
    signed_op = s;
  endtask

  task automatic test_reset();
    arst_n = 1'b0; start = 1'b0; signed_op = 1'b0; op_a = '0; op_b = '0;
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
    total++; if (product !== 32'h0) begin bad++; $display("FAIL reset_product got=%h want=00000000", product); end
    @(negedge clk);
    arst_n = 1'b1;
  endtask

  // busy in cycles 1..8, done only in cycle 9; high multiplier bits keep
  // the full latency in both builds.
  task automatic test_unsigned_max();
    start_op(16'hFFFF, 16'hFFFF, 1'b0);
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
      total++; if (busy !== (c <= 8)) begin bad++; $display("FAIL max_busy c=%0d got=%b want=%b", c, busy, (c <= 8)); end
      total++; if (done !== (c == 9)) begin bad++; $display("FAIL max_done c=%0d got=%b want=%b", c, done, (c == 9)); end
    end
    total++; if (product !== 32'hFFFE0001) begin bad++; $display("FAIL max_product got=%h want=fffe0001", product); end
  endtask

  task automatic test_products();
    vec_t v[8];
    int   c;
    v[0] = '{16'hFFFD, 16'h0007, 1'b1, 32'hFFFFFFEB, EARLY ? 3 : 9};
    v[1] = '{16'h8000, 16'h8000, 1'b1, 32'h40000000, 9};
    v[2] = '{16'h8000, 16'h8000, 1'b0, 32'h40000000, 9};
    v[3] = '{16'hFFFD, 16'h0007, 1'b0, 32'h0006FFEB, EARLY ? 3 : 9};
    v[4] = '{16'h8000, 16'h0001, 1'b1, 32'hFFFF8000, EARLY ? 2 : 9};
    v[5] = '{16'h1234, 16'h0003, 1'b0, 32'h0000369C, EARLY ? 2 : 9};
    v[6] = '{16'h0007, 16'hFFFD, 1'b1, 32'hFFFFFFEB, EARLY ? 2 : 9};
    v[7] = '{16'h0000, 16'h1234, 1'b0, 32'h00000000, EARLY ? 8 : 9};
    for (int i = 0; i < 8; i++) begin
      start_op(v[i].a, v[i].b, v[i].s);
      c = 0;
      while (done !== 1'b1 && c < 20) begin
        @(negedge clk);
        c++;
        if (c == 1) start = 1'b0;
      end
      total++; if (c != v[i].lat) begin bad++; $display("FAIL prod_latency vec=%0d got=%0d want=%0d", i, c, v[i].lat); end
      total++; if (product !== v[i].p) begin bad++; $display("FAIL prod_value vec=%0d got=%h want=%h", i, product, v[i].p); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL prod_busy_at_done vec=%0d got=%b want=0", i, busy); end
    end
  endtask

  // A start raised mid-calculation is dropped; the first result completes
  // on time and the unit then returns to idle.
  task automatic test_ignored_start();
    logic [15:0] b1;
    logic [31:0] p1;
    b1 = EARLY ? 16'h8003 : 16'h0003;
    p1 = EARLY ? 32'h0002800F : 32'h0000000F;
    start_op(16'h0005, b1, 1'b0);
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
      if (c == 3) begin start = 1'b1; op_a = 16'hFFFF; op_b = 16'hFFFF; end
      if (c == 4) start = 1'b0;
      total++; if (busy !== (c <= 8)) begin bad++; $display("FAIL ign_busy c=%0d got=%b want=%b", c, busy, (c <= 8)); end
      total++; if (done !== (c == 9)) begin bad++; $display("FAIL ign_done c=%0d got=%b want=%b", c, done, (c == 9)); end
      if (c >= 9) begin
        total++; if (product !== p1) begin bad++; $display("FAIL ign_product c=%0d got=%h want=%h", c, product, p1); end
      end
    end
  endtask

  // start in the DONE cycle is accepted; the old result stays visible until
  // the new one is written.
  task automatic test_back_to_back();
    logic [15:0] b1, b2;
    logic [31:0] p1, p2;
    b1 = EARLY ? 16'h8003 : 16'h0003;
    p1 = EARLY ? 32'h0002800F : 32'h0000000F;
    b2 = EARLY ? 16'h8004 : 16'h0004;
    p2 = EARLY ? 32'h00010008 : 32'h00000008;
    start_op(16'h0005, b1, 1'b0);
    for (int c = 1; c <= 18; c++) begin
      @(negedge clk);
      if (c == 1)  start = 1'b0;
      if (c == 9)  begin start = 1'b1; op_a = 16'h0002; op_b = b2; signed_op = 1'b0; end
      if (c == 10) start = 1'b0;
      if (c == 9) begin
        total++; if (done !== 1'b1) begin bad++; $display("FAIL b2b_first_done got=%b want=1", done); end
      end
      if (c >= 10 && c <= 17) begin
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL b2b_busy c=%0d got=%b want=1", c, busy); end
      end
      if (c >= 9 && c <= 17) begin
        total++; if (product !== p1) begin bad++; $display("FAIL b2b_hold c=%0d got=%h want=%h", c, product, p1); end
      end
      if (c == 18) begin
        total++; if (done !== 1'b1) begin bad++; $display("FAIL b2b_second_done got=%b want=1", done); end
        total++; if (product !== p2) begin bad++; $display("FAIL b2b_second_product got=%h want=%h", product, p2); end
      end
    end
  endtask

  // Reset mid-calculation clears outputs combinationally; the edge right
  // after release accepts a fresh start.
  task automatic test_async_reset();
    int c;
    start_op(16'h1234, 16'h5678, 1'b0);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
    end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL arst_busy_before got=%b want=1", busy); end
    #2 arst_n = 1'b0;
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL arst_busy got=%b want=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL arst_done got=%b want=0", done); end
    total++; if (product !== 32'h0) begin bad++; $display("FAIL arst_product got=%h want=00000000", product); end
    start = 1'b1; op_a = 16'h0006; op_b = 16'h0007; signed_op = 1'b0;
    #1 arst_n = 1'b1;
    c = 0;
    while (done !== 1'b1 && c < 20) begin
      @(negedge clk);
      c++;
      if (c == 1) start = 1'b0;
    end
    total++; if (c != (EARLY ? 3 : 9)) begin bad++; $display("FAIL arst_latency got=%0d want=%0d", c, (EARLY ? 3 : 9)); end
    total++; if (product !== 32'h0000002A) begin bad++; $display("FAIL arst_product_after got=%h want=0000002a", product); end
  endtask

  initial begin
    test_reset();
    test_unsigned_max();
    test_products();
    test_ignored_start();
    test_back_to_back();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute time limit so the bench can never hang.
  initial begin
    #100000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "simulation time limit reached");
  end

endmodule : tb_mult_iter
`default_nettype wire
